// File: rtl/dog_status_encoder.sv
// Action/speed status encoder for the two-digit 7-segment display stage.
// Define BLINK_EN to blink both digits during the hold after a change.
module dog_status_encoder #(
  parameter int HOLD_CYCLES  = 25_000_000,
  parameter int BLINK_CYCLES = 6_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [2:0] action,
  input  logic [1:0] speed,
  output logic [6:0] seg_act,
  output logic [6:0] seg_spd,
  output logic       digit1_en,
  output logic       digit4_en,
  output logic       busy,
  output logic       act_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int HCW = $clog2(HOLD_CYCLES);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  localparam logic [6:0] SEG_P    = 7'b0001100;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  function automatic logic [6:0] enc_act(input logic [2:0] a);
    logic [6:0] s;
    case (a)
      3'd0:    s = 7'b0001100;
      3'd1:    s = 7'b0001000;
      3'd2:    s = 7'b1000110;
      3'd3:    s = 7'b1000111;
      3'd4:    s = 7'b0100001;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] enc_spd(input logic [1:0] v);
    logic [6:0] s;
    case (v)
      2'd0:    s = 7'b1000000;
      2'd1:    s = 7'b1111001;
      2'd2:    s = 7'b0100100;
      2'd3:    s = 7'b0110000;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  state_t         state_r;
  state_t         next_state_s;
  logic [2:0]     act_r;
  logic [1:0]     spd_r;
  logic [HCW-1:0] hold_cnt_r;
  logic [6:0]     seg_act_r;
  logic [6:0]     seg_spd_r;
  logic           act_err_r;
  logic           hs_s;
  logic           changed_s;

  assign upd_ready = (state_r == IDLE) && !rst;
  assign busy      = (state_r != IDLE);
  assign hs_s      = upd_valid && upd_ready;
  assign changed_s = (action != act_r) || (speed != spd_r);
  assign seg_act   = seg_act_r;
  assign seg_spd   = seg_spd_r;
  assign act_err   = act_err_r;

  // Next-state decode; a same-value update is accepted without leaving IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s && changed_s) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: next_state_s = HOLD;
      HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, captured pair, encoded segments and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      act_r      <= 3'd0;
      spd_r      <= 2'd0;
      hold_cnt_r <= '0;
      seg_act_r  <= SEG_P;
      seg_spd_r  <= SEG_ZERO;
      act_err_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (hs_s) begin
        act_r <= action;
        spd_r <= speed;
      end
      case (state_r)
        LOAD: begin
          seg_act_r  <= enc_act(act_r);
          seg_spd_r  <= enc_spd(spd_r);
          act_err_r  <= (act_r > 3'd4);
          hold_cnt_r <= '0;
        end
        HOLD: begin
          // Saturate at the terminal count; the FSM leaves HOLD there.
          if (hold_cnt_r != HOLD_LAST) begin
            hold_cnt_r <= hold_cnt_r + HCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BLINK_EN
  localparam int BCW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_CYCLES - 1);

  logic [BCW-1:0] blink_cnt_r;
  logic           blink_en_r;

  // Blink toggle: dark from the first HOLD cycle, steady on outside HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_r <= '0;
      blink_en_r  <= 1'b1;
    end else begin
      case (state_r)
        LOAD: begin
          blink_cnt_r <= '0;
          blink_en_r  <= 1'b0;
        end
        HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            blink_cnt_r <= '0;
            blink_en_r  <= 1'b1;
          end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            blink_en_r  <= ~blink_en_r;
          end else begin
            blink_cnt_r <= blink_cnt_r + BCW'(1);
          end
        end
        default: begin
          blink_cnt_r <= '0;
          blink_en_r  <= 1'b1;
        end
      endcase
    end
  end

  assign digit1_en = blink_en_r;
  assign digit4_en = blink_en_r;
`else
  assign digit1_en = 1'b1;
  assign digit4_en = 1'b1;
`endif

endmodule

// File: tb/tb_dog_status_encoder.sv
// Scoreboard bench for dog_status_encoder (HOLD_CYCLES=8, BLINK_CYCLES=2);
// blink expectations follow the BLINK_EN define.
module tb_dog_status_encoder;

  localparam int HC = 8;
  localparam int BC = 2;

  typedef struct packed {
    logic [6:0] sa;
    logic [6:0] ss;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       upd_valid;
  logic       upd_ready;
  logic [2:0] action;
  logic [1:0] speed;
  logic [6:0] seg_act;
  logic [6:0] seg_spd;
  logic       digit1_en;
  logic       digit4_en;
  logic       busy;
  logic       act_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   hs_cyc  = 0;
  exp_t sb_q[$];
  logic [2:0] m_act;
  logic [1:0] m_spd;
  logic prev_busy = 1'b0;
  logic pending   = 1'b0;

  dog_status_encoder #(.HOLD_CYCLES(HC), .BLINK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .action(action), .speed(speed), .seg_act(seg_act), .seg_spd(seg_spd),
    .digit1_en(digit1_en), .digit4_en(digit4_en), .busy(busy), .act_err(act_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_act(input logic [2:0] a);
    case (a)
      3'd0:    return 7'b0001100;
      3'd1:    return 7'b0001000;
      3'd2:    return 7'b1000110;
      3'd3:    return 7'b1000111;
      3'd4:    return 7'b0100001;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_spd(input logic [1:0] v);
    case (v)
      2'd0:    return 7'b1000000;
      2'd1:    return 7'b1111001;
      2'd2:    return 7'b0100100;
      default: return 7'b0110000;
    endcase
  endfunction

  function automatic logic exp_en_hold(input int idx);
`ifdef BLINK_EN
    return (((idx - 1) / BC) % 2) == 1;
`else
    return idx >= 0;
`endif
  endfunction

  // Monitor: LOAD seen (busy rising) -> compare the next cycle against the queue head.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pending   = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (pending) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("seg_act", {25'd0, seg_act}, {25'd0, e.sa});
          check("seg_spd", {25'd0, seg_spd}, {25'd0, e.ss});
          check("act_err", {31'd0, act_err}, {31'd0, e.err});
        end
        pending = 1'b0;
      end
      if (busy && !prev_busy) pending = 1'b1;
      prev_busy = busy;
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!upd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rdy_wait", {31'd0, upd_ready}, 32'd1);
  endtask

  task automatic send(input logic [2:0] a, input logic [1:0] s);
    @(negedge clk);
    action    = a;
    speed     = s;
    upd_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    hs_cyc = cyc;
    #1 upd_valid = 1'b0;
    if (a != m_act || s != m_spd) begin
      sb_q.push_back('{sa: exp_act(a), ss: exp_spd(s), err: (a > 3'd4)});
    end
    m_act = a;
    m_spd = s;
  endtask

  task automatic check_same();
    @(negedge clk);
    check("same_busy", {31'd0, busy}, 32'd0);
    check("same_ready", {31'd0, upd_ready}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_seg_act"}, {25'd0, seg_act}, 32'b0001100);
    check({tag, "_seg_spd"}, {25'd0, seg_spd}, 32'b1000000);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, act_err}, 32'd0);
    check({tag, "_en"}, {30'd0, digit1_en, digit4_en}, 32'd3);
  endtask

  initial begin
    int lo;
    int t0;
    rst       = 1'b1;
    upd_valid = 1'b1;
    action    = 3'd3;
    speed     = 2'd3;
    m_act     = 3'd0;
    m_spd     = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, upd_ready}, 32'd0);
    rst       = 1'b0;
    upd_valid = 1'b0;
    @(negedge clk);
    check("rel_ready", {31'd0, upd_ready}, 32'd1);
    check_reset_vals("rel");

    // Stored pair must still be (0,0): reset beat the concurrent request.
    send(3'd0, 2'd0);
    check_same();

    // First change: ready low for LOAD + HOLD, enables follow the blink pattern.
    send(3'd1, 2'd2);
    lo = 0;
    @(negedge clk);
    while (!upd_ready && lo < 100) begin
      if (lo == 0) check("en_load", {31'd0, digit1_en}, 32'd1);
      else check("en_hold", {30'd0, digit1_en, digit4_en}, exp_en_hold(lo) ? 32'd3 : 32'd0);
      lo++;
      @(negedge clk);
    end
    check("ready_low", lo, HC + 1);
    check("en_after", {30'd0, digit1_en, digit4_en}, 32'd3);

    // Back-to-back changes with upd_valid held through HOLD.
    send(3'd1, 2'd1);
    t0 = hs_cyc;
    send(3'd2, 2'd1);
    check("spacing", hs_cyc - t0, HC + 2);
    wait_ready();

    send(3'd2, 2'd1);
    check_same();
    check("same_seg", {25'd0, seg_act}, 32'b1000110);

    send(3'd6, 2'd3);
    send(3'd3, 2'd0);
    wait_ready();

    // Reset in the middle of HOLD.
    send(3'd4, 2'd2);
    repeat (5) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, upd_ready}, 32'd0);
    @(negedge clk);
    check_reset_vals("mid");
    rst   = 1'b0;
    m_act = 3'd0;
    m_spd = 2'd0;
    send(3'd0, 2'd0);
    check_same();

    send(3'd4, 2'd3);
    wait_ready();
    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
